// File: rtl/conv_accum_ctrl_pkg.sv
// Package conv_pkg: shared definitions for the convolution accumulate controller.
//   - default datapath dimensions and the derived accumulator width
//   - clog2 helper used for the derivation
//   - FSM state encoding (IDLE=0, ACCUM=1, OUT=2)
//   - sign_extend helper shared with the adder-array stage
// Optional feature macro consumed elsewhere: CONV_ACCUM_RELU_EN.
package conv_pkg;

  localparam int DATA_W_DEF    = 17;
  localparam int LANES_DEF     = 4;
  localparam int MAX_TERMS_DEF = 9;

  // Ceiling log2 for elaboration-time width math; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Enough headroom that MAX_TERMS full-scale terms can never wrap.
  localparam int ACC_W_DEF = DATA_W_DEF + clog2(MAX_TERMS_DEF);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ACCUM = ACCUM,
    ST_OUT   = OUT
  } state_t;

  // Sign-extends the low dw bits of d to 64 bits; callers truncate to their
  // accumulator width. dw is always an elaboration constant at call sites.
  function automatic logic signed [63:0] sign_extend(input logic [63:0] d, input int dw);
    logic signed [63:0] t;
    t = $signed(d << (64 - dw));
    return t >>> (64 - dw);
  endfunction

endpackage

// File: rtl/conv_accum_ctrl_if.sv
// Interface conv_accum_ctrl_if: control, input stream and output stream of the
// convolution accumulate controller.
//   start/num_terms   window request (num_terms latched on accepted start)
//   in_valid/in_ready/in_data     LANES x DATA_W partial-product vectors
//   out_valid/out_ready/out_data  LANES x ACC_W per-lane sums
//   busy, err_len     status
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; the source holds data stable while
// valid is high and ready is low, and ready never depends on valid.
// Modports: master = window source / result sink, slave = the controller.
interface conv_accum_ctrl_if #(
  parameter int DATA_W = 17,
  parameter int LANES  = 4,
  parameter int ACC_W  = 21
);
  logic                    start;
  logic [3:0]              num_terms;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W*LANES-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W*LANES-1:0]  out_data;
  logic                    busy;
  logic                    err_len;

  modport master (
    output start, num_terms, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, err_len
  );

  modport slave (
    input  start, num_terms, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, err_len
  );
endinterface

// File: rtl/conv_accum_lane.sv
// conv_accum_lane: one signed accumulator lane.
//   clk, reset  clock and asynchronous active-high reset
//   clr         synchronous clear (start of a window)
//   en          add d_in this cycle (input handshake)
//   d_in        DATA_W two's-complement term
//   acc         ACC_W running sum
module conv_accum_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d_in,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] d_ext;

  assign d_ext = ACC_W'(sign_extend(64'(d_in), DATA_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + d_ext;
    end
  end

endmodule

// File: rtl/conv_accum_ctrl.sv
// conv_accum_ctrl: sequences a LANES-wide accumulate over one convolution window.
// Accepts num_terms input vectors, sums them per lane with no wrap, and holds
// the widened sums on the output stream until consumed.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; aborts any window in progress
//   bus        conv_accum_ctrl_if.slave (start/num_terms, in_*, out_*, busy, err_len)
//   dbg_state  current FSM state
// Build option: CONV_ACCUM_RELU_EN clamps negative lane sums to zero on out_data.
module conv_accum_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  localparam int ACC_W    = DATA_W + clog2(MAX_TERMS)
) (
  input  logic              clk,
  input  logic              reset,
  conv_accum_ctrl_if.slave  bus,
  output state_t            dbg_state
);

  localparam logic [3:0] MAX_T = 4'(MAX_TERMS);

  state_t     state_q, state_d;
  logic [3:0] count_q;
  logic [3:0] terms_q;
  logic       err_q;

  logic       len_ok;
  logic       start_acc;
  logic       start_bad;
  logic       in_fire;
  logic       last_term;
  logic       out_fire;

  logic [ACC_W-1:0] acc [LANES];

  assign len_ok    = (bus.num_terms != 4'd0) && (bus.num_terms <= MAX_T);
  assign start_acc = (state_q == ST_IDLE) && bus.start && len_ok;
  assign start_bad = (state_q == ST_IDLE) && bus.start && !len_ok;
  assign in_fire   = (state_q == ST_ACCUM) && bus.in_valid;
  assign last_term = (count_q == terms_q - 4'd1);
  assign out_fire  = (state_q == ST_OUT) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_ACCUM;
      ST_ACCUM: if (in_fire && last_term) state_d = ST_OUT;
      ST_OUT:   if (out_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      terms_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_acc) begin
        count_q <= '0;
        terms_q <= bus.num_terms;
      end else if (in_fire) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

  // Stream flags are pure decodes of the state register, so in_ready rises the
  // cycle after an accepted start and falls on the edge of the last accept.
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err_len   = err_q;
  assign dbg_state     = state_q;

  // Accumulators are frozen outside ACCUM, so they double as the output register.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_accum_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (start_acc),
      .en    (in_fire),
      .d_in  (bus.in_data[i*DATA_W +: DATA_W]),
      .acc   (acc[i])
    );

`ifdef CONV_ACCUM_RELU_EN
    assign bus.out_data[i*ACC_W +: ACC_W] = acc[i][ACC_W-1] ? '0 : acc[i];
`else
    assign bus.out_data[i*ACC_W +: ACC_W] = acc[i];
`endif
  end

endmodule
